// File: rtl/axis_packet_fifo_pkg.sv
// Shared definitions for the packet FIFO: write-side FSM encodings and a
// constant log2 helper used to size pointers from the depth parameter.
package axis_packet_fifo_pkg;

    // Write-side FSM: ACCEPT stores beats, DROP discards the rest of a rejected packet.
    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_packet_fifo_ram.sv
// Simple dual-port RAM with one write port and one registered read port on a
// single clock. No reset on the array or read register so it maps onto block RAM.
module axis_packet_fifo_ram #(
    parameter int unsigned Width = 65,
    parameter int unsigned Depth = 1024,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [Width-1:0] rd_data_o
);

    logic [Width-1:0] mem_q [Depth];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/axis_packet_fifo.sv
// Packet-granular AXI-Stream FIFO. Beats become visible downstream only after
// their packet's tlast is stored; packets that do not fit are dropped whole and
// counted, so the input side is never back-pressured.
module axis_packet_fifo
    import axis_packet_fifo_pkg::*;
#(
    parameter int unsigned C_AXIS_WIDTH = 64,
    parameter int unsigned C_DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_AXIS_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             fifo_occupancy,
    output logic [31:0]             drop_count,
    output logic                    overflow
);

    localparam int unsigned AddrW        = clog2(C_DEPTH);
    localparam int unsigned PtrW         = AddrW + 1;
    localparam int unsigned WordW        = C_AXIS_WIDTH + 1;
    localparam int unsigned BytesPerWord = C_AXIS_WIDTH / 8;
    localparam logic [PtrW-1:0] DepthP   = PtrW'(C_DEPTH);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

    wr_state_e         state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PtrW-1:0]   rd_addr_q, rd_addr_d;
    logic [PtrW-1:0]   out_ptr_q, out_ptr_d;
    logic [31:0]       drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       occ_q, occ_d;
    logic              tready_q;
    logic              ram_vld_q, ram_vld_d;
    logic              out_vld_q, out_vld_d;
    logic [WordW-1:0]  out_word_q, out_word_d;

    logic              in_beat;
    logic              full;
    logic [PtrW-1:0]   used;
    logic [PtrW-1:0]   pending;
    logic              ram_we;
    logic              ram_re;
    logic              stage_load;
    logic              out_hs;
    logic [WordW-1:0]  ram_rd_data;

    assign in_beat = s_axis_tvalid && tready_q;
    // Occupancy is taken against the read address, so a slot freed by a read
    // this cycle only becomes writable next cycle.
    assign used    = wr_ptr_q - rd_addr_q;
    assign full    = (used == DepthP);
    assign pending = commit_ptr_q - out_ptr_q;

    // Write FSM: store beats while space remains, otherwise rewind and drop the packet.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_count_d = drop_count_q;
        overflow_d   = 1'b0;
        ram_we       = 1'b0;
        unique case (state_q)
            ST_ACCEPT: begin
                if (in_beat) begin
                    if (!full) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrOne;
                        if (s_axis_tlast) begin
                            commit_ptr_d = wr_ptr_q + PtrOne;
                        end
                    end else begin
                        wr_ptr_d   = commit_ptr_q;
                        overflow_d = 1'b1;
                        if (drop_count_q != 32'hFFFF_FFFF) begin
                            drop_count_d = drop_count_q + 32'd1;
                        end
                        if (!s_axis_tlast) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (in_beat && s_axis_tlast) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // Read pipeline: RAM read register feeds the output register; a read is
    // issued only when the RAM stage is empty or moving forward this cycle.
    always_comb begin
        out_hs     = out_vld_q && m_axis_tready;
        stage_load = ram_vld_q && (!out_vld_q || m_axis_tready);
        ram_re     = (rd_addr_q != commit_ptr_q) && (!ram_vld_q || stage_load);
        rd_addr_d  = ram_re ? rd_addr_q + PtrOne : rd_addr_q;
        out_ptr_d  = out_hs ? out_ptr_q + PtrOne : out_ptr_q;
        ram_vld_d  = ram_vld_q;
        if (ram_re) begin
            ram_vld_d = 1'b1;
        end else if (stage_load) begin
            ram_vld_d = 1'b0;
        end
        out_vld_d  = out_vld_q;
        out_word_d = out_word_q;
        if (stage_load) begin
            out_vld_d  = 1'b1;
            out_word_d = ram_rd_data;
        end else if (out_hs) begin
            out_vld_d = 1'b0;
        end
        occ_d = 32'(pending) * 32'(BytesPerWord);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_addr_q    <= '0;
            out_ptr_q    <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            occ_q        <= '0;
            tready_q     <= 1'b0;
            ram_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_addr_q    <= rd_addr_d;
            out_ptr_q    <= out_ptr_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            occ_q        <= occ_d;
            tready_q     <= 1'b1;
            ram_vld_q    <= ram_vld_d;
            out_vld_q    <= out_vld_d;
            out_word_q   <= out_word_d;
        end
    end

    axis_packet_fifo_ram #(
        .Width(WordW),
        .Depth(C_DEPTH),
        .AddrW(AddrW)
    ) u_ram (
        .clk_i    (clk),
        .wr_en_i  (ram_we),
        .wr_addr_i(wr_ptr_q[AddrW-1:0]),
        .wr_data_i({s_axis_tlast, s_axis_tdata}),
        .rd_en_i  (ram_re),
        .rd_addr_i(rd_addr_q[AddrW-1:0]),
        .rd_data_o(ram_rd_data)
    );

    assign s_axis_tready  = tready_q;
    assign m_axis_tvalid  = out_vld_q;
    assign m_axis_tlast   = out_word_q[WordW-1];
    assign m_axis_tdata   = out_word_q[C_AXIS_WIDTH-1:0];
    assign fifo_occupancy = occ_q;
    assign drop_count     = drop_count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: directed packet scenarios plus randomized
// streaming, checked against a queue-based packet model.
module tb_axis_packet_fifo;

    localparam int unsigned W   = 64;
    localparam int unsigned D   = 16;
    localparam int unsigned BPW = W / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [31:0]   fifo_occupancy;
    logic [31:0]   drop_count;
    logic          overflow;

    always #5 clk = ~clk;

    axis_packet_fifo #(
        .C_AXIS_WIDTH(W),
        .C_DEPTH(D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_occupancy(fifo_occupancy),
        .drop_count    (drop_count),
        .overflow      (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: committed words awaiting output, and the packet being received.
    logic [W:0] exp_q[$];
    logic [W:0] cur_q[$];
    int         lvl       = 0;  // committed minus handed-off words
    int         lvl_prev  = 0;  // same, one edge earlier
    bit         drop_mode = 1'b0;
    int         words_out = 0;
    int         ovf_pulses = 0;
    logic [31:0] drop_model = 32'd0;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes before the edge, update model, check after it.
    task automatic tick();
        logic       s_hs, m_hs, rst_pre;
        logic [W:0] s_word, m_word, want;
        rst_pre = rst_n;
        s_hs    = s_axis_tvalid && s_axis_tready;
        m_hs    = m_axis_tvalid && m_axis_tready;
        s_word  = {s_axis_tlast, s_axis_tdata};
        m_word  = {m_axis_tlast, m_axis_tdata};
        @(posedge clk);
        #1;
        if (!rst_pre) begin
            exp_q.delete();
            cur_q.delete();
            lvl        = 0;
            lvl_prev   = 0;
            drop_model = 32'd0;
            return;
        end
        if (s_hs) begin
            cur_q.push_back(s_word);
            if (s_word[W]) begin
                if (!drop_mode) begin
                    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                    lvl += cur_q.size();
                end
                cur_q.delete();
            end
        end
        if (m_hs) begin
            check("m_word_expected", (W+1)'(exp_q.size() != 0), (W+1)'(1));
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("m_word", m_word, want);
            end
            lvl--;
            words_out++;
        end
        check("occupancy", (W+1)'(fifo_occupancy), (W+1)'(lvl_prev * BPW));
        lvl_prev = lvl;
        check("overflow_follows_beat", (W+1)'(overflow && !s_hs), (W+1)'(0));
        drop_model = drop_model + 32'(overflow);
        check("drop_count_step", (W+1)'(drop_count), (W+1)'(drop_model));
        if (overflow) ovf_pulses++;
    endtask

    task automatic drive_word(input logic [W-1:0] data, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [W-1:0] base);
        for (int i = 0; i < len; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + W'(i);
            s_axis_tlast  = (i == len - 1);
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, (W+1)'(s_axis_tready), (W+1)'(0));
        check({tag, "_tvalid"}, (W+1)'(m_axis_tvalid), (W+1)'(0));
        check({tag, "_tlast"}, (W+1)'(m_axis_tlast), (W+1)'(0));
        check({tag, "_tdata"}, (W+1)'(m_axis_tdata), (W+1)'(0));
        check({tag, "_occ"}, (W+1)'(fifo_occupancy), (W+1)'(0));
        check({tag, "_drops"}, (W+1)'(drop_count), (W+1)'(0));
        check({tag, "_overflow"}, (W+1)'(overflow), (W+1)'(0));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_out;
        int len;
        int guard;
        int sent;

        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", (W+1)'(s_axis_tready), (W+1)'(1));

        // Basic commit: 4 words, occupancy 32 one cycle after tlast.
        m_axis_tready = 1'b1;
        base_out = words_out;
        send_pkt(4, 64'h1);
        check("basic_occ_at_commit", (W+1)'(fifo_occupancy), (W+1)'(0));
        tick();
        check("basic_occ_after", (W+1)'(fifo_occupancy), (W+1)'(32));
        drain(20);
        check("basic_words", (W+1)'(words_out - base_out), (W+1)'(4));
        check("basic_occ_end", (W+1)'(fifo_occupancy), (W+1)'(0));

        // Partial visibility: nothing leaves until tlast is stored.
        base_out = words_out;
        drive_word(64'hA0, 1'b0);
        drive_word(64'hA1, 1'b0);
        drive_word(64'hA2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("partial_tvalid", (W+1)'(m_axis_tvalid), (W+1)'(0));
            check("partial_occ", (W+1)'(fifo_occupancy), (W+1)'(0));
        end
        drive_word(64'hA3, 1'b1);
        m_axis_tready = 1'b0;
        tick();
        check("partial_tvalid_n1", (W+1)'(m_axis_tvalid), (W+1)'(0));
        tick();
        check("partial_tvalid_n2", (W+1)'(m_axis_tvalid), (W+1)'(1));
        check("partial_first", (W+1)'(m_axis_tdata), (W+1)'(64'hA0));
        m_axis_tready = 1'b1;
        drain(20);
        check("partial_words", (W+1)'(words_out - base_out), (W+1)'(4));

        // Fill and drop: 12 words kept, 8-word packet rejected whole.
        m_axis_tready = 1'b0;
        ovf_pulses = 0;
        send_pkt(12, 64'h100);
        tick();
        tick();
        tick();
        check("fill_occ", (W+1)'(fifo_occupancy), (W+1)'(96));
        drop_mode = 1'b1;
        send_pkt(8, 64'h200);
        drop_mode = 1'b0;
        tick();
        tick();
        check("fill_drops", (W+1)'(drop_count), (W+1)'(1));
        check("fill_pulses", (W+1)'(ovf_pulses), (W+1)'(1));
        check("fill_occ_kept", (W+1)'(fifo_occupancy), (W+1)'(96));
        base_out = words_out;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("fill_words_out", (W+1)'(words_out - base_out), (W+1)'(12));
        check("fill_tvalid_idle", (W+1)'(m_axis_tvalid), (W+1)'(0));

        // Oversize: 20-word packet dropped once, next packet intact.
        drop_mode = 1'b1;
        send_pkt(20, 64'h300);
        drop_mode = 1'b0;
        tick();
        check("oversize_drops", (W+1)'(drop_count), (W+1)'(2));
        check("oversize_pulses", (W+1)'(ovf_pulses), (W+1)'(2));
        check("oversize_occ", (W+1)'(fifo_occupancy), (W+1)'(0));
        base_out = words_out;
        send_pkt(2, 64'h400);
        drain(20);
        check("oversize_next_words", (W+1)'(words_out - base_out), (W+1)'(2));

        // Back-to-back streaming with random gaps and random output ready.
        base_out = words_out;
        sent = 0;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 8);
            guard = 0;
            while (lvl + len > int'(D) && guard < 500) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
                tick();
                guard++;
            end
            check("stream_space_wait", (W+1)'(guard < 500), (W+1)'(1));
            for (int i = 0; i < len;) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) != 0) begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = {$urandom, $urandom};
                    s_axis_tlast  = (i == len - 1);
                    i++;
                end else begin
                    s_axis_tvalid = 1'b0;
                    s_axis_tlast  = 1'b0;
                end
                tick();
            end
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            sent += len;
        end
        m_axis_tready = 1'b1;
        drain(100);
        check("stream_all_out", (W+1)'(words_out - base_out), (W+1)'(sent));
        check("stream_no_drops", (W+1)'(drop_count), (W+1)'(2));

        // Reset mid-packet with one packet committed.
        m_axis_tready = 1'b0;
        send_pkt(3, 64'h500);
        drive_word(64'h600, 1'b0);
        drive_word(64'h601, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'h602;
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        s_axis_tvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("midreset_ready", (W+1)'(s_axis_tready), (W+1)'(1));
        m_axis_tready = 1'b1;
        base_out = words_out;
        send_pkt(3, 64'h700);
        drain(20);
        check("midreset_words", (W+1)'(words_out - base_out), (W+1)'(3));
        check("midreset_occ", (W+1)'(fifo_occupancy), (W+1)'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packet_fifo.md
# axis_packet_fifo

Packet-granular AXI-Stream FIFO that sits directly upstream of `circular_dma` and feeds its `s_axis_s2mm` input and its `fifo_occupancy` input. Incoming packets are buffered and become visible downstream only once their `tlast` beat is stored, so the DMA never sizes a transfer around a partial packet. A packet that does not fit is dropped whole and counted, so the input side never back-pressures the capture logic.

## Interface
- `C_AXIS_WIDTH`, 64: data width in bits; multiple of 8.
- `C_DEPTH`, 1024: storage in words; power of two, ≥ 4.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `s_axis_tdata`  in  C_AXIS_WIDTH  input data.
- `s_axis_tlast`  in  1  end of packet.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  C_AXIS_WIDTH  output data, to `circular_dma` `s_axis_s2mm_tdata`.
- `m_axis_tlast`  out  1  end of packet.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  output ready.
- `fifo_occupancy`  out  32  committed, not yet transferred bytes; to `circular_dma` `fifo_occupancy`.
- `drop_count`  out  32  packets dropped since reset; saturates at 0xFFFFFFFF.
- `overflow`  out  1  one-cycle pulse per dropped packet.

## Operation
- **Pointers.** Pointers are log2(C_DEPTH)+1 bits and wrap naturally.
  - `wr_ptr`: next write slot.
  - `commit_ptr`: one past the last stored `tlast`.
  - `rd_addr`: next RAM read.
  - `out_ptr`: count of words handed off on m_axis.
- **Free space.** `free = C_DEPTH − (wr_ptr − rd_addr)`, evaluated on registered values. A slot freed by a read in the same cycle is not visible to a write in that cycle.
- **Write FSM state ACCEPT.** On each beat (`tvalid && tready`):
  - If `free > 0`: store `{tlast, tdata}` at `wr_ptr`; `wr_ptr++`. If `tlast`, also `commit_ptr <= wr_ptr+1`.
  - If `free == 0`: `wr_ptr <= commit_ptr` (rewind); `drop_count++` (saturating); pulse `overflow`. If the beat has `tlast`, stay in ACCEPT; otherwise go to DROP.
- **Write FSM state DROP.** Discard beats. A `tlast` beat returns the FSM to ACCEPT. No further increments of `drop_count` for this packet.
- **Oversize packets.** A packet longer than C_DEPTH words is always dropped.
- **Read side.**
  - RAM read issues when `rd_addr != commit_ptr` and the output register is empty or emptying this cycle.
  - Data lands in the output register one cycle later.
  - `m_axis_tvalid` holds with stable data until `m_axis_tready`.
- **Occupancy.** `fifo_occupancy = (commit_ptr − out_ptr) × C_AXIS_WIDTH/8`, registered, zero-extended to 32 bits.
- **Input ready.** `s_axis_tready` = 1 whenever not in reset. Input is never back-pressured.

## Timing
- **Reset values.** During reset and on the first cycle after it:
  - `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - `fifo_occupancy` = 0, `drop_count` = 0, `overflow` = 0.
  - All pointers = 0; FSM = ACCEPT.
- **Reset mid-packet.** Partial and committed contents are discarded. No drop is counted.
- **Commit to output.** `tlast` beat accepted at edge N:
  - `commit_ptr` updates at edge N.
  - `fifo_occupancy` reflects the commit after edge N+1.
  - RAM read issues in cycle N+1; `m_axis_tvalid` is high after edge N+2.
- **Throughput.** One word per cycle on each side with `m_axis_tready` held high. No bubbles between packets.
- **Occupancy on handoff.** `fifo_occupancy` drops by C_AXIS_WIDTH/8 one cycle after each m_axis handshake.
- **Simultaneous commit and handoff.** In the same cycle, both apply: net change = committed words − 1.
- **Overflow pulse.** `overflow` rises one cycle after the rejected beat. `drop_count` updates on the same edge.

## Structure
- Sub-module `axis_packet_fifo_ram`: simple dual-port RAM, registered read, one write port and one read port on `clk`, width C_AXIS_WIDTH+1, depth C_DEPTH. Written so synthesis infers BRAM.
- Shared defs header (alongside `circular_dma` defs): `clog2` function, FSM state encodings `ST_ACCEPT` and `ST_DROP`.
- Everything else lives as localparams in the top module.

## Test plan
- **Basic commit.** Reset, then a 4-word packet (0x1..0x4, `tlast` on 0x4) → occupancy goes 0 → 32 one cycle after `tlast`. m_axis emits the 4 words in order, `tlast` on 0x4. Occupancy returns to 0.
- **Partial visibility.** Send 3 words without `tlast`, then idle 10 cycles → `m_axis_tvalid` = 0 and occupancy = 0 throughout. Send `tlast` → output starts 2 cycles later.
- **Fill and drop.** C_DEPTH = 16, `m_axis_tready` = 0. Send a 12-word packet, then an 8-word packet → first packet kept (occupancy 96). Second packet rewound; `drop_count` = 1 with one `overflow` pulse. Release `tready` → exactly 12 words out.
- **Oversize.** C_DEPTH = 16, send a 20-word packet → `drop_count` increments once. Occupancy stays 0. A following 2-word packet is delivered intact.
- **Back-to-back streaming.** 100 packets of random length 1..8, random `m_axis_tready` → output data matches input exactly. Occupancy equals the model every cycle. No drops.
- **Reset mid-packet.** Assert `rst_n` = 0 during word 3 of 5 with one packet committed → all outputs at reset values. The next packet is delivered correctly, with no stale data.
